uart_rx: RTL

UART receiver for the 8N1 serial link driven by `uart_tx`: deserialises the `tx` line back into bytes at 115200 baud from the 50 MHz system clock. It sits directly downstream of `uart_tx`, either in loopback for bring-up or facing the external host. It delivers each received byte with a one-cycle valid strobe and flags malformed frames.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART blocks (uart_tx / uart_rx).
//   UART_CLKS_PER_BIT : default clock cycles per bit (50 MHz / 115200)
//   UART_DATA_W       : data bits per frame
//   uart_state_e      : receiver/transmitter frame state
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int unsigned UART_CLKS_PER_BIT = 434;
  localparam int unsigned UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing an asynchronous single-bit input into the
// clock domain.
//   RESET_VAL : value both flops take during reset
//   clk_i     : destination clock
//   rst_ni    : asynchronous active-low reset
//   d_i       : asynchronous input
//   q_o       : synchronized output (2-cycle latency)
// ----------------------------------------------------------------------------
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver (optional even parity). Deserialises the serial line into
// bytes, strobing rx_complete for one cycle per good byte and flagging bad
// stop bits (frame_err) and parity mismatches (parity_err).
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit; otherwise parity_err is tied low.
//
// Ports:
//   clk_50M     : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rx          : serial input, idle high, asynchronous to clk_50M
//   rx_msg      : last correctly received byte (holds until next good byte)
//   rx_complete : one-cycle pulse, rx_msg updated
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, parity mismatch with good stop bit
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] rx_msg,
  output logic                   rx_complete,
  output logic                   frame_err,
  output logic                   parity_err
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic rx_s;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk_50M),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [UART_DATA_W-1:0] msg_q, msg_d;
  logic                   armed_q, armed_d;
  logic                   complete_q, complete_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    msg_d      = msg_q;
    armed_d    = armed_q;
    complete_d = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A line that is still low after a bad stop bit (break) must go
        // high before a new start bit is accepted.
        if (!armed_q) begin
          armed_d = rx_s;
        end else if (!rx_s) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            armed_d = 1'b1;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          // A good stop bit leaves the line high, so re-arm immediately to
          // accept a back-to-back start bit.
          armed_d = rx_s;
          if (!rx_s) begin
            ferr_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_q != ^shift_q) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            msg_d      = shift_q;
            complete_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      msg_q      <= '0;
      armed_q    <= 1'b0;
      complete_q <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      msg_q      <= msg_d;
      armed_q    <= armed_d;
      complete_q <= complete_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_msg      = msg_q;
  assign rx_complete = complete_q;
  assign frame_err   = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule
